// File: rtl/alarma_ctrl_if.sv
// ============================================================================
// Module      : alarma_ctrl_if
// Description : Time/alarm inputs and ring-status outputs of the alarm control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface alarma_ctrl_if;
  logic       tick_1s;
  logic [7:0] hora_act;
  logic [7:0] min_act;
  logic [7:0] seg_act;
  logic [7:0] hora_al;
  logic [7:0] min_al;
  logic       alarma_en;
  logic       apagar;
  logic       activar_alarma;
  logic       parpadeo;
  logic [7:0] seg_rest;

  modport master (
    output tick_1s, hora_act, min_act, seg_act, hora_al, min_al, alarma_en, apagar,
    input  activar_alarma, parpadeo, seg_rest
  );

  modport slave (
    input  tick_1s, hora_act, min_act, seg_act, hora_al, min_al, alarma_en, apagar,
    output activar_alarma, parpadeo, seg_rest
  );
endinterface

`default_nettype wire

// File: rtl/alarma_ctrl.sv
// ============================================================================
// Module      : alarma_ctrl
// Description : Alarm clock ring controller: arm, ring with countdown, silence.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alarma_ctrl #(
  parameter int RING_SECS = 60
) (
  input  wire logic    clk,
  input  wire logic    reset,
  alarma_ctrl_if.slave bus
);

  localparam logic [1:0] DESHAB   = 2'd0;
  localparam logic [1:0] ARMADA   = 2'd1;
  localparam logic [1:0] SONANDO  = 2'd2;
  localparam logic [1:0] SILENCIO = 2'd3;

  localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

  logic [1:0] state_q,    state_d;
  logic       apagar_q,   apagar_d;
  logic [7:0] seg_rest_q, seg_rest_d;
  logic       parpadeo_q, parpadeo_d;

  logic match;
  logic apagar_rise;

  assign match = bus.tick_1s
               && (bus.hora_act == bus.hora_al)
               && (bus.min_act  == bus.min_al)
               && (bus.seg_act  == 8'h00);

  assign apagar_rise = bus.apagar & ~apagar_q;

  always_comb begin
    state_d    = state_q;
    seg_rest_d = seg_rest_q;
    parpadeo_d = parpadeo_q;
    apagar_d   = bus.apagar;

    case (state_q)
      DESHAB: begin
        if (bus.alarma_en) begin
          state_d = ARMADA;
        end
      end

      ARMADA: begin
        if (!bus.alarma_en) begin
          state_d = DESHAB;
        end else if (match) begin
          // The matching tick only starts the ring; it is not counted down.
          state_d    = SONANDO;
          seg_rest_d = RING_LOAD;
          parpadeo_d = 1'b1;
        end
      end

      SONANDO: begin
        if (!bus.alarma_en) begin
          state_d    = DESHAB;
          seg_rest_d = 8'd0;
          parpadeo_d = 1'b0;
        end else if (apagar_rise || (bus.tick_1s && (seg_rest_q == 8'd1))) begin
          state_d    = SILENCIO;
          seg_rest_d = 8'd0;
          parpadeo_d = 1'b0;
        end else if (bus.tick_1s) begin
          seg_rest_d = seg_rest_q - 8'd1;
          parpadeo_d = ~parpadeo_q;
        end
      end

      SILENCIO: begin
        // Hold off re-arming until the alarm minute has passed.
        if (!bus.alarma_en) begin
          state_d = DESHAB;
        end else if (bus.min_act != bus.min_al) begin
          state_d = ARMADA;
        end
      end

      default: begin
        state_d    = DESHAB;
        seg_rest_d = 8'd0;
        parpadeo_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DESHAB;
      apagar_q   <= 1'b0;
      seg_rest_q <= 8'd0;
      parpadeo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      apagar_q   <= apagar_d;
      seg_rest_q <= seg_rest_d;
      parpadeo_q <= parpadeo_d;
    end
  end

  assign bus.activar_alarma = (state_q == SONANDO);
  assign bus.parpadeo       = parpadeo_q;
  assign bus.seg_rest       = seg_rest_q;

endmodule

`default_nettype wire

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl: a 60 s instance and a 1 s instance share stimulus.
`default_nettype none

module tb_alarma_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] hora_act, min_act, seg_act, hora_al, min_al;
  logic       en, apagar;

  int n_pass = 0;
  int n_tot  = 0;

  alarma_ctrl_if if60 ();
  alarma_ctrl_if if1 ();

  assign if60.tick_1s = tick;     assign if1.tick_1s = tick;
  assign if60.hora_act = hora_act; assign if1.hora_act = hora_act;
  assign if60.min_act = min_act;   assign if1.min_act = min_act;
  assign if60.seg_act = seg_act;   assign if1.seg_act = seg_act;
  assign if60.hora_al = hora_al;   assign if1.hora_al = hora_al;
  assign if60.min_al = min_al;     assign if1.min_al = min_al;
  assign if60.alarma_en = en;      assign if1.alarma_en = en;
  assign if60.apagar = apagar;     assign if1.apagar = apagar;

  alarma_ctrl #(.RING_SECS(60)) dut60 (.clk(clk), .reset(reset), .bus(if60.slave));
  alarma_ctrl #(.RING_SECS(1))  dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    reset = 1'b1; tick = 1'b0; en = 1'b0; apagar = 1'b0;
    hora_act = 8'h07; min_act = 8'h29; seg_act = 8'h59;
    hora_al = 8'h07; min_al = 8'h30;
    step(); step();
    chk("rst_act",  {7'd0, if60.activar_alarma}, 8'd0);
    chk("rst_seg",  if60.seg_rest, 8'd0);
    chk("rst_par",  {7'd0, if60.parpadeo}, 8'd0);
    reset = 1'b0;
    en = 1'b1;
    step();

    // 07:29:59 -> 07:30:00 matches
    min_act = 8'h30; seg_act = 8'h00; tick = 1'b1;
    step(); tick = 1'b0;
    chk("match_act", {7'd0, if60.activar_alarma}, 8'd1);
    chk("match_seg", if60.seg_rest, 8'd60);
    chk("match_par", {7'd0, if60.parpadeo}, 8'd1);
    chk("r1_act",    {7'd0, if1.activar_alarma}, 8'd1);
    chk("r1_seg",    if1.seg_rest, 8'd1);

    // Full 60 s ring, clock advancing to 07:31:00
    for (int k = 1; k <= 60; k++) begin
      if (k == 60) begin min_act = 8'h31; seg_act = 8'h00; end
      else seg_act = bcd(k);
      tick = 1'b1;
      step(); tick = 1'b0;
      if (k < 60) begin
        chk("ring_act", {7'd0, if60.activar_alarma}, 8'd1);
        chk("ring_seg", if60.seg_rest, 8'(60 - k));
        chk("ring_par", {7'd0, if60.parpadeo}, (k % 2 == 0) ? 8'd1 : 8'd0);
      end else begin
        chk("end_act", {7'd0, if60.activar_alarma}, 8'd0);
        chk("end_seg", if60.seg_rest, 8'd0);
        chk("end_par", {7'd0, if60.parpadeo}, 8'd0);
      end
      if (k == 1) begin
        chk("r1_end_act", {7'd0, if1.activar_alarma}, 8'd0);
        chk("r1_end_seg", if1.seg_rest, 8'd0);
      end
      step();
    end

    // Both rearmed at 07:31; a new 07:30:00 match must ring again
    min_act = 8'h30; seg_act = 8'h00; tick = 1'b1;
    step(); tick = 1'b0;
    chk("rearm_act", {7'd0, if60.activar_alarma}, 8'd1);
    chk("rearm_seg", if60.seg_rest, 8'd60);
    chk("rearm_r1",  {7'd0, if1.activar_alarma}, 8'd1);

    // 15 ticks with alarm hour edited mid-ring, then stop button held
    for (int k = 1; k <= 15; k++) begin
      seg_act = bcd(k);
      if (k == 5)  hora_al = 8'h08;
      if (k == 10) hora_al = 8'h07;
      tick = 1'b1;
      step(); tick = 1'b0;
      step();
    end
    chk("s45_act", {7'd0, if60.activar_alarma}, 8'd1);
    chk("s45_seg", if60.seg_rest, 8'd45);
    chk("s45_par", {7'd0, if60.parpadeo}, 8'd0);
    apagar = 1'b1;
    step();
    chk("stop_act", {7'd0, if60.activar_alarma}, 8'd0);
    chk("stop_seg", if60.seg_rest, 8'd0);
    chk("stop_par", {7'd0, if60.parpadeo}, 8'd0);
    repeat (4) step();
    chk("stop_hold", {7'd0, if60.activar_alarma}, 8'd0);
    apagar = 1'b0;
    step();

    // Silenced within the alarm minute: a fresh 07:30:00 tick must not retrigger
    seg_act = 8'h00; tick = 1'b1;
    step(); tick = 1'b0;
    chk("sil_act",    {7'd0, if60.activar_alarma}, 8'd0);
    chk("sil_r1_act", {7'd0, if1.activar_alarma}, 8'd0);

    // Disable together with stop press goes to DESHAB
    min_act = 8'h31;
    step(); step();
    min_act = 8'h30; tick = 1'b1;
    step(); tick = 1'b0;
    chk("p4_act", {7'd0, if60.activar_alarma}, 8'd1);
    apagar = 1'b1; en = 1'b0;
    step();
    chk("dis_act",    {7'd0, if60.activar_alarma}, 8'd0);
    chk("dis_seg",    if60.seg_rest, 8'd0);
    chk("dis_r1_act", {7'd0, if1.activar_alarma}, 8'd0);
    apagar = 1'b0; en = 1'b1;
    step();
    tick = 1'b1;
    step(); tick = 1'b0;
    chk("reen_act", {7'd0, if60.activar_alarma}, 8'd1);
    chk("reen_seg", if60.seg_rest, 8'd60);

    // Asynchronous reset between edges while ringing
    #3;
    reset = 1'b1;
    #1;
    chk("arst_act", {7'd0, if60.activar_alarma}, 8'd0);
    chk("arst_seg", if60.seg_rest, 8'd0);
    chk("arst_par", {7'd0, if60.parpadeo}, 8'd0);
    en = 1'b0;
    step(); step();
    reset = 1'b0;
    tick = 1'b1;
    step(); tick = 1'b0;
    chk("post_rst_act", {7'd0, if60.activar_alarma}, 8'd0);
    chk("post_rst_r1",  {7'd0, if1.activar_alarma}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

`default_nettype wire
